// File: rtl/bcd_clock_display_scan_if.sv
// Display scan bus: BCD time fields and display controls in, segment/digit drives out.
interface bcd_clock_display_scan_if;
  logic [7:0] Hour;
  logic [7:0] Minute;
  logic [7:0] Second;
  logic [2:0] BlinkSel;
  logic       ColonOn;
  logic [6:0] Seg;
  logic [5:0] Dig;
  logic       Dp;

  modport master (
    output Hour, Minute, Second, BlinkSel, ColonOn,
    input  Seg, Dig, Dp
  );

  modport slave (
    input  Hour, Minute, Second, BlinkSel, ColonOn,
    output Seg, Dig, Dp
  );
endinterface

// File: rtl/bcd_clock_display_scan.sv
// 6-digit multiplexed common-anode 7-segment scanner for the HH:MM:SS clock.
// Per-frame input snapshot, dead time between slots, leading-zero blanking,
// dash for non-BCD nibbles and per-field blinking.
//
// state   | meaning
// --------+-------------------------------
// SLOT_HT | digit 0, hour tens
// SLOT_HU | digit 1, hour units (colon dp)
// SLOT_MT | digit 2, minute tens
// SLOT_MU | digit 3, minute units (colon dp)
// SLOT_ST | digit 4, second tens
// SLOT_SU | digit 5, second units; snapshot taken at its last cycle
module bcd_clock_display_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD         = 2,
  parameter int BLINK_FRAMES = 83,
  parameter int LZB          = 1
) (
  input  logic                      CP,
  input  logic                      CR,
  bcd_clock_display_scan_if.slave   bus
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] DEAD_CNT   = SW'(DEAD);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic [2:0] {
    SLOT_HT = 3'd0,
    SLOT_HU = 3'd1,
    SLOT_MT = 3'd2,
    SLOT_MU = 3'd3,
    SLOT_ST = 3'd4,
    SLOT_SU = 3'd5
  } slot_t;

  slot_t         slot, slot_nxt;
  logic [SW-1:0] scan_cnt, scan_nxt;
  logic [FW-1:0] frame_cnt, frame_nxt;
  logic          blink_phase, phase_nxt;
  logic          snap_load;
  logic [7:0]    snap_hour, snap_min, snap_sec;

  logic [3:0]    nibble;
  logic          field_blink;
  logic [6:0]    seg_d, seg_q;
  logic [5:0]    dig_d, dig_q;
  logic          dp_d, dp_q;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h3F;
    endcase
  endfunction

  // State register: scan timer, slot, blink timing and the frame snapshot.
  always_ff @(posedge CP) begin
    if (CR) begin
      scan_cnt    <= '0;
      slot        <= SLOT_HT;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      snap_hour   <= '0;
      snap_min    <= '0;
      snap_sec    <= '0;
    end else begin
      scan_cnt    <= scan_nxt;
      slot        <= slot_nxt;
      frame_cnt   <= frame_nxt;
      blink_phase <= phase_nxt;
      if (snap_load) begin
        snap_hour <= bus.Hour;
        snap_min  <= bus.Minute;
        snap_sec  <= bus.Second;
      end
    end
  end

  // Next state: advance the slot at terminal count; frame end loads the snapshot and steps blink.
  always_comb begin
    scan_nxt  = scan_cnt + 1'b1;
    slot_nxt  = slot;
    frame_nxt = frame_cnt;
    phase_nxt = blink_phase;
    snap_load = 1'b0;
    if (scan_cnt == SCAN_LAST) begin
      scan_nxt = '0;
      case (slot)
        SLOT_HT: slot_nxt = SLOT_HU;
        SLOT_HU: slot_nxt = SLOT_MT;
        SLOT_MT: slot_nxt = SLOT_MU;
        SLOT_MU: slot_nxt = SLOT_ST;
        SLOT_ST: slot_nxt = SLOT_SU;
        SLOT_SU: begin
          slot_nxt  = SLOT_HT;
          snap_load = 1'b1;
          if (frame_cnt == FRAME_LAST) begin
            frame_nxt = '0;
            phase_nxt = ~blink_phase;
          end else begin
            frame_nxt = frame_cnt + 1'b1;
          end
        end
        default: slot_nxt = SLOT_HT;
      endcase
    end
  end

  // Output decode for the current slot; the dead window keeps every digit dark.
  always_comb begin
    case (slot)
      SLOT_HT: begin nibble = snap_hour[7:4]; field_blink = bus.BlinkSel[0]; end
      SLOT_HU: begin nibble = snap_hour[3:0]; field_blink = bus.BlinkSel[0]; end
      SLOT_MT: begin nibble = snap_min[7:4];  field_blink = bus.BlinkSel[1]; end
      SLOT_MU: begin nibble = snap_min[3:0];  field_blink = bus.BlinkSel[1]; end
      SLOT_ST: begin nibble = snap_sec[7:4];  field_blink = bus.BlinkSel[2]; end
      SLOT_SU: begin nibble = snap_sec[3:0];  field_blink = bus.BlinkSel[2]; end
      default: begin nibble = 4'd0;           field_blink = 1'b0;            end
    endcase

    seg_d = 7'h7F;
    dig_d = 6'h3F;
    dp_d  = 1'b1;
    if (scan_cnt >= DEAD_CNT) begin
      dig_d = ~(6'b000001 << slot);
      seg_d = seg_decode(nibble);
      // Hour tens of zero goes dark but the digit stays enabled to keep brightness even.
      if ((LZB != 0) && (slot == SLOT_HT) && (nibble == 4'd0))
        seg_d = 7'h7F;
      if (blink_phase && field_blink)
        seg_d = 7'h7F;
      if ((slot == SLOT_HU) || (slot == SLOT_MU))
        dp_d = ~bus.ColonOn;
    end
  end

  // Output register: one cycle behind the scan state, all dark under reset.
  always_ff @(posedge CP) begin
    if (CR) begin
      seg_q <= 7'h7F;
      dig_q <= 6'h3F;
      dp_q  <= 1'b1;
    end else begin
      seg_q <= seg_d;
      dig_q <= dig_d;
      dp_q  <= dp_d;
    end
  end

  assign bus.Seg = seg_q;
  assign bus.Dig = dig_q;
  assign bus.Dp  = dp_q;

endmodule

// File: tb/tb_bcd_clock_display_scan.sv
// Directed bench for bcd_clock_display_scan with SCAN_DIV=4, DEAD=1, BLINK_FRAMES=2.
// A second instance with LZB=0 covers the unblanked hour-tens case.
module tb_bcd_clock_display_scan;
  logic       CP = 1'b0;
  logic       CR;
  logic [7:0] hour, minute, second;
  logic [2:0] blink_sel;
  logic       colon_on;
  int         checks = 0;
  int         errors = 0;
  int         n = 0;

  logic [5:0] dig_tab [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
  logic [6:0] seg_2359 [6] = '{7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h00};
  logic [6:0] blink_s2 [6] = '{7'h40, 7'h12, 7'h7F, 7'h7F, 7'h12, 7'h12};
  logic [6:0] blink_s3 [6] = '{7'h40, 7'h10, 7'h7F, 7'h7F, 7'h10, 7'h10};

  bcd_clock_display_scan_if bus ();
  bcd_clock_display_scan_if bus0 ();

  assign bus.Hour      = hour;
  assign bus.Minute    = minute;
  assign bus.Second    = second;
  assign bus.BlinkSel  = blink_sel;
  assign bus.ColonOn   = colon_on;
  assign bus0.Hour     = hour;
  assign bus0.Minute   = minute;
  assign bus0.Second   = second;
  assign bus0.BlinkSel = blink_sel;
  assign bus0.ColonOn  = colon_on;

  bcd_clock_display_scan #(.SCAN_DIV(4), .DEAD(1), .BLINK_FRAMES(2), .LZB(1)) dut (
    .CP(CP), .CR(CR), .bus(bus.slave)
  );

  bcd_clock_display_scan #(.SCAN_DIV(4), .DEAD(1), .BLINK_FRAMES(2), .LZB(0)) dut0 (
    .CP(CP), .CR(CR), .bus(bus0.slave)
  );

  always #5 CP = ~CP;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [6:0] se, input logic [5:0] de, input logic pe);
    chk({tag, ".seg"}, {1'b0, bus.Seg}, {1'b0, se});
    chk({tag, ".dig"}, {2'b0, bus.Dig}, {2'b0, de});
    chk({tag, ".dp"},  {7'b0, bus.Dp},  {7'b0, pe});
  endtask

  // n counts rising edges since reset release; sampling is on the falling edge.
  task automatic tick();
    @(negedge CP);
    n++;
  endtask

  // Advance until the outputs show frame f, slot s, scan count c.
  task automatic wait_to(input int f, input int s, input int c);
    int target;
    target = 24 * f + 4 * s + c + 1;
    if (target < n) begin
      errors++;
      $error("FAIL schedule f=%0d s=%0d c=%0d observed_cycle=%0d expected_cycle=%0d", f, s, c, n, target);
    end
    while (n < target) tick();
  endtask

  initial begin
    CR = 1'b1;
    hour = 8'h00; minute = 8'h00; second = 8'h00;
    blink_sel = 3'b000; colon_on = 1'b0;

    // Reset held three cycles: everything dark.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("reset", 7'h7F, 6'h3F, 1'b1);
      chk("reset.lzb0.dig", {2'b0, bus0.Dig}, 8'h3F);
    end

    // Release; the new time is only picked up at the end of frame 0.
    CR = 1'b0;
    n = 0;
    hour = 8'h23; minute = 8'h59; second = 8'h58;

    wait_to(0, 0, 0);
    chk_out("f0.dead", 7'h7F, 6'h3F, 1'b1);
    wait_to(0, 0, 1);
    chk_out("f0.s0", 7'h7F, 6'h3E, 1'b1);
    chk("f0.s0.lzb0.seg", {1'b0, bus0.Seg}, 8'h40);
    for (int s = 1; s < 6; s++) begin
      wait_to(0, s, 1);
      chk_out($sformatf("f0.s%0d", s), 7'h40, dig_tab[s], 1'b1);
    end

    // Frame 1: 23:59:58, seconds change mid-frame must not show.
    for (int s = 0; s < 6; s++) begin
      wait_to(1, s, 0);
      chk_out($sformatf("f1.s%0d.dead", s), 7'h7F, 6'h3F, 1'b1);
      wait_to(1, s, 1);
      chk_out($sformatf("f1.s%0d", s), seg_2359[s], dig_tab[s], 1'b1);
      wait_to(1, s, 3);
      chk($sformatf("f1.s%0d.end.seg", s), {1'b0, bus.Seg}, {1'b0, seg_2359[s]});
      if (s == 2) second = 8'h59;
    end

    wait_to(2, 5, 1);
    chk_out("f2.s5", 7'h10, 6'h1F, 1'b1);

    // Hour 05, minute 6A (bad units nibble), colon on.
    hour = 8'h05; minute = 8'h6A; colon_on = 1'b1;
    wait_to(3, 0, 1);
    chk_out("f3.s0", 7'h7F, 6'h3E, 1'b1);
    chk("f3.s0.lzb0.seg", {1'b0, bus0.Seg}, 8'h40);
    wait_to(3, 1, 0);
    chk_out("f3.s1.dead", 7'h7F, 6'h3F, 1'b1);
    wait_to(3, 1, 1);
    chk_out("f3.s1", 7'h12, 6'h3D, 1'b0);
    wait_to(3, 2, 1);
    chk_out("f3.s2", 7'h02, 6'h3B, 1'b1);
    wait_to(3, 3, 1);
    chk_out("f3.s3", 7'h3F, 6'h37, 1'b0);
    wait_to(3, 4, 1);
    chk_out("f3.s4", 7'h12, 6'h2F, 1'b1);

    // Blink minutes across frames 0..5 after a fresh reset.
    colon_on = 1'b0;
    hour = 8'h23; minute = 8'h59; second = 8'h59;
    blink_sel = 3'b010;
    CR = 1'b1;
    tick();
    tick();
    chk_out("reset2", 7'h7F, 6'h3F, 1'b1);
    CR = 1'b0;
    n = 0;
    for (int f = 0; f < 6; f++) begin
      wait_to(f, 2, 1);
      chk_out($sformatf("blink.f%0d.s2", f), blink_s2[f], 6'h3B, 1'b1);
      wait_to(f, 3, 1);
      chk_out($sformatf("blink.f%0d.s3", f), blink_s3[f], 6'h37, 1'b1);
      if (f == 2) begin
        wait_to(f, 5, 1);
        chk_out("blink.f2.s5", 7'h10, 6'h1F, 1'b1);
      end
    end
    wait_to(6, 2, 1);
    chk_out("blink.f6.s2", 7'h7F, 6'h3B, 1'b1);

    // Single-cycle reset pulse in the middle of slot 4.
    wait_to(6, 4, 2);
    chk_out("pulse.pre", 7'h12, 6'h2F, 1'b1);
    CR = 1'b1;
    tick();
    chk_out("pulse", 7'h7F, 6'h3F, 1'b1);
    CR = 1'b0;
    n = 0;
    wait_to(0, 0, 0);
    chk_out("restart.dead", 7'h7F, 6'h3F, 1'b1);
    wait_to(0, 0, 1);
    chk_out("restart.s0", 7'h7F, 6'h3E, 1'b1);
    wait_to(0, 2, 1);
    chk_out("restart.s2", 7'h40, 6'h3B, 1'b1);
    wait_to(1, 2, 1);
    chk_out("restart.f1.s2", 7'h12, 6'h3B, 1'b1);
    wait_to(2, 2, 1);
    chk_out("restart.f2.s2", 7'h7F, 6'h3B, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
